// File: rtl/mem_unit_pkg.sv
// Shared types for the memory-stage load/store unit: width codes, FSM states, latched request.
package mem_unit_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 3;

  localparam logic [TAG_W-1:0] TAG_NONE = 3'd0;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  typedef struct packed {
    logic [1:0]        width;
    logic              sgn;
    logic [DATA_W-1:0] wdata;
    logic [TAG_W-1:0]  num;
  } req_t;

  // Width code 3 falls through to a full word.
  function automatic logic [2:0] xfer_bytes(input logic [1:0] width);
    case (width)
      W_BYTE:  return 3'd1;
      W_HALF:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_unit_if.sv
// Issue-side request bundle of the load/store unit; ready is combinational from the unit.
interface mem_unit_if;
  import mem_unit_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_width;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_num;

  modport master (
    output req_valid, req_we, req_width, req_signed, req_addr, req_wdata, req_num,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_we, req_width, req_signed, req_addr, req_wdata, req_num,
    output req_ready
  );

endinterface

// File: rtl/mem_unit_load_extend.sv
// Sign/zero extension of assembled little-endian load bytes; purely combinational, no flow control.
module load_extend
  import mem_unit_pkg::*;
(
  input  logic [DATA_W-1:0] lanes,
  input  logic [1:0]        width,
  input  logic              sgn,
  output logic [DATA_W-1:0] value
);

  always_comb begin
    value = lanes;
    case (width)
      W_BYTE:  value = {{24{sgn & lanes[7]}}, lanes[7:0]};
      W_HALF:  value = {{16{sgn & lanes[15]}}, lanes[15:0]};
      default: value = lanes;
    endcase
  end

endmodule

// File: rtl/mem_unit.sv
// Byte-serial load/store unit: one request at a time, LB/LH/LW = 3/4/6 cycles, stores N+1; pause freezes it.
// MEM_UNIT_MISALIGN_EN: misaligned half/word completes in one cycle with misalign_out instead of RAM traffic.
module mem_unit
  import mem_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  mem_unit_if.slave         req_if,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr,
  output logic [DATA_W-1:0] data_out,
  output logic [TAG_W-1:0]  num_out
`ifdef MEM_UNIT_MISALIGN_EN
  ,
  output logic              misalign_out
`endif
);

  state_t            state, state_nxt;
  req_t              op;
  logic [2:0]        cnt;
  logic              pend;
  logic [1:0]        pend_idx;
  logic [DATA_W-1:0] lanes, lanes_nxt, ld_val;
  logic [2:0]        n_bytes;
  logic [1:0]        nxt_lane;
  logic              accept;

  assign req_if.req_ready = (state == IDLE) & ~pause;
  assign accept           = req_if.req_valid & req_if.req_ready;
  assign n_bytes          = xfer_bytes(op.width);
  assign nxt_lane         = cnt[1:0] + 2'd1;
  assign mem_wr           = (state == WR) & ~pause;

`ifdef MEM_UNIT_MISALIGN_EN
  logic misalign;
  assign misalign = (req_if.req_width == W_HALF) ? req_if.req_addr[0]
                  : (req_if.req_width != W_BYTE) && (req_if.req_addr[1:0] != 2'b00);
`endif

  // A byte addressed in a live cycle lands on mem_din one cycle later and is taken even if paused.
  always_comb begin
    lanes_nxt = lanes;
    if (pend) lanes_nxt[{pend_idx, 3'b000} +: 8] = mem_din;
  end

  load_extend u_ext (
    .lanes (lanes_nxt),
    .width (op.width),
    .sgn   (op.sgn),
    .value (ld_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
`ifdef MEM_UNIT_MISALIGN_EN
        if (misalign) state_nxt = DONE; else
`endif
        state_nxt = req_if.req_we ? WR : RD;
      end
      RD:      if (!pause && cnt == n_bytes) state_nxt = DONE;
      WR:      if (!pause && cnt == n_bytes - 3'd1) state_nxt = DONE;
      DONE:    if (!pause) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op       <= '0;
      cnt      <= '0;
      pend     <= 1'b0;
      pend_idx <= '0;
      lanes    <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
      data_out <= '0;
      num_out  <= TAG_NONE;
`ifdef MEM_UNIT_MISALIGN_EN
      misalign_out <= 1'b0;
`endif
    end else begin
      lanes <= lanes_nxt;
      pend  <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op  <= '{width: req_if.req_width, sgn: req_if.req_signed,
                   wdata: req_if.req_wdata, num: req_if.req_num};
          cnt <= '0;
`ifdef MEM_UNIT_MISALIGN_EN
          misalign_out <= misalign;
          if (misalign) begin
            data_out <= '0;
            num_out  <= req_if.req_num;
          end else
`endif
          begin
            mem_a    <= req_if.req_addr;
            mem_dout <= req_if.req_wdata[7:0];
          end
        end
        RD: if (!pause) begin
          if (cnt != n_bytes) begin
            pend     <= 1'b1;
            pend_idx <= cnt[1:0];
            cnt      <= cnt + 3'd1;
            if (cnt + 3'd1 < n_bytes) mem_a <= mem_a + 32'd1;
          end else begin
            data_out <= ld_val;
            num_out  <= op.num;
          end
        end
        WR: if (!pause) begin
          if (cnt == n_bytes - 3'd1) begin
            data_out <= '0;
            num_out  <= op.num;
          end else begin
            cnt      <= cnt + 3'd1;
            mem_a    <= mem_a + 32'd1;
            mem_dout <= op.wdata[{nxt_lane, 3'b000} +: 8];
          end
        end
        DONE: if (!pause) begin
          data_out <= '0;
          num_out  <= TAG_NONE;
`ifdef MEM_UNIT_MISALIGN_EN
          misalign_out <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit: transaction-level model of latency, RAM traffic and results.
module tb_mem_unit;
  import mem_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pause = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [31:0] data_out;
  logic [2:0]  num_out;
`ifdef MEM_UNIT_MISALIGN_EN
  logic        misalign_out;
`endif

  mem_unit_if req_if();

  mem_unit dut (
    .clk      (clk),
    .rst      (rst),
    .pause    (pause),
    .req_if   (req_if),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_a    (mem_a),
    .mem_wr   (mem_wr),
    .data_out (data_out),
    .num_out  (num_out)
`ifdef MEM_UNIT_MISALIGN_EN
    ,
    .misalign_out (misalign_out)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM, 4 KiB window aliased over the address space.
  logic [7:0]  ram [4096];
  logic        pk_en = 1'b0;
  logic [11:0] pk_a = '0;
  logic [7:0]  pk_d = '0;

  always @(posedge clk) begin
    mem_din <= ram[mem_a[11:0]];
    if (mem_wr)     ram[mem_a[11:0]] <= mem_dout;
    else if (pk_en) ram[pk_a] <= pk_d;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model state of the transaction in flight.
  logic        m_active = 1'b0;
  logic        m_we = 1'b0;
  logic        m_mis = 1'b0;
  int          m_n = 0, m_L = 0, m_cyc = 0, m_paused = 0;
  logic [31:0] m_addr = '0, m_wd = '0, m_data = '0;
  logic [2:0]  m_tag = '0;
  logic        vis_seen = 1'b0;
  int          vis_cyc = 0;
  logic [31:0] vis_data = '0;
  logic [2:0]  vis_tag = '0;

  function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input logic sg);
    logic [31:0] v = '0;
    logic [31:0] ai;
    logic [31:0] mask;
    for (int i = 0; i < n; i++) begin
      ai = a + i;
      v[8*i +: 8] = ram[ai[11:0]];
    end
    if (sg && n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      if (v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Cycle c of a transaction has eff = c - (paused cycles before c); address eff-1 is on the bus
  // for eff in 1..N and the result shows once eff reaches the latency, until a live cycle.
  always @(negedge clk) begin
    int eff;
    if (m_active) begin
      m_cyc++;
      eff = m_cyc - m_paused;
      chk("ready_busy", {31'd0, req_if.req_ready}, 32'd0);
      if (eff >= m_L) begin
        chk("num_out", {29'd0, num_out}, {29'd0, m_tag});
        chk("data_out", data_out, m_data);
`ifdef MEM_UNIT_MISALIGN_EN
        chk("misalign", {31'd0, misalign_out}, {31'd0, m_mis});
`endif
        if (!vis_seen) begin
          vis_seen = 1'b1;
          vis_cyc  = m_cyc;
          vis_data = data_out;
          vis_tag  = num_out;
        end
        if (!pause) m_active = 1'b0;
      end else begin
        chk("num_out_early", {29'd0, num_out}, 32'd0);
        chk("data_out_early", data_out, 32'd0);
      end
      if (eff >= 1 && eff <= m_n) begin
        chk("mem_a", mem_a, m_addr + eff - 1);
        if (m_we) chk("mem_dout", {24'd0, mem_dout}, {24'd0, m_wd[8*(eff-1) +: 8]});
      end
      chk("mem_wr", {31'd0, mem_wr}, {31'd0, (m_we && eff >= 1 && eff <= m_n && !pause)});
      if (pause) m_paused++;
    end else begin
      chk("ready_idle", {31'd0, req_if.req_ready}, {31'd0, !pause});
      chk("num_out_idle", {29'd0, num_out}, 32'd0);
      chk("data_out_idle", data_out, 32'd0);
      chk("mem_wr_idle", {31'd0, mem_wr}, 32'd0);
    end
  end

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pk_a = a; pk_d = d; pk_en = 1'b1;
    @(posedge clk); #1;
    pk_en = 1'b0;
  endtask

  task automatic do_op(input logic we, input logic [1:0] w, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [2:0] tag,
                       input int pstart, input int plen, input int abort_at,
                       input logic [31:0] lit_data, input int lit_cyc);
    int n;
    logic aborted = 1'b0;
    @(posedge clk); #1;
    req_if.req_valid  = 1'b1;
    req_if.req_we     = we;
    req_if.req_width  = w;
    req_if.req_signed = sg;
    req_if.req_addr   = a;
    req_if.req_wdata  = wd;
    req_if.req_num    = tag;
    n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    m_mis = 1'b0;
`ifdef MEM_UNIT_MISALIGN_EN
    if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) m_mis = 1'b1;
`endif
    m_we     = we;
    m_addr   = a;
    m_wd     = wd;
    m_tag    = tag;
    m_n      = m_mis ? 0 : n;
    m_L      = m_mis ? 1 : (we ? n + 1 : n + 2);
    m_data   = (we || m_mis) ? 32'd0 : model_load(a, n, sg);
    vis_seen = 1'b0;
    @(posedge clk); #1;
    req_if.req_valid = 1'b0;
    m_cyc    = 0;
    m_paused = 0;
    m_active = 1'b1;
    for (int c = 1; c <= 300 && m_active; c++) begin
      if (c == abort_at) begin
        m_active = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_num_out", {29'd0, num_out}, 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        aborted = 1'b1;
      end else begin
        pause = (c >= pstart && c < pstart + plen);
        @(posedge clk); #1;
      end
    end
    pause = 1'b0;
    if (m_active) begin
      chk("timeout", 32'd1, 32'd0);
      m_active = 1'b0;
    end
    if (!aborted && lit_cyc > 0) begin
      chk("lit_seen", {31'd0, vis_seen}, 32'd1);
      chk("lit_cycle", vis_cyc, lit_cyc);
      chk("lit_data", vis_data, lit_data);
      chk("lit_tag", {29'd0, vis_tag}, {29'd0, tag});
    end
  endtask

  initial begin
    req_if.req_valid  = 1'b0;
    req_if.req_we     = 1'b0;
    req_if.req_width  = 2'd0;
    req_if.req_signed = 1'b0;
    req_if.req_addr   = '0;
    req_if.req_wdata  = '0;
    req_if.req_num    = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset_mem_a", mem_a, 32'd0);
    chk("reset_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("reset_data_out", data_out, 32'd0);
    chk("reset_num_out", {29'd0, num_out}, 32'd0);
    chk("reset_ready", {31'd0, req_if.req_ready}, 32'd1);
`ifdef MEM_UNIT_MISALIGN_EN
    chk("reset_misalign", {31'd0, misalign_out}, 32'd0);
`endif
    poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
    poke(12'h040, 8'h80); poke(12'h202, 8'hAA);
    poke(12'h300, 8'h00); poke(12'h301, 8'h00); poke(12'h302, 8'h00); poke(12'h303, 8'h00);
    poke(12'hFFF, 8'h34); poke(12'h000, 8'h92);
    rst = 1'b0;

    //    we    w     sg    addr           wdata          tag   ps pl ab  literal        cyc
    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         3'd3, 0, 0, 0, 32'h1234_5678, 6);
    do_op(1'b0, 2'd0, 1'b1, 32'h0000_0040, 32'h0,         3'd1, 0, 0, 0, 32'hFFFF_FF80, 3);
    do_op(1'b0, 2'd0, 1'b0, 32'h0000_0040, 32'h0,         3'd2, 0, 0, 0, 32'h0000_0080, 3);
    do_op(1'b1, 2'd1, 1'b0, 32'h0000_0200, 32'h1234_BEEF, 3'd5, 0, 0, 0, 32'h0,         3);
    chk("ram_200", {24'd0, ram[12'h200]}, 32'h0000_00EF);
    chk("ram_201", {24'd0, ram[12'h201]}, 32'h0000_00BE);
    chk("ram_202", {24'd0, ram[12'h202]}, 32'h0000_00AA);
    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         3'd3, 2, 3, 0, 32'h1234_5678, 9);
    do_op(1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0,         3'd6, 0, 0, 0, 32'h0000_1234, 4);
    do_op(1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0,         3'd1, 3, 2, 0, 32'h0000_0056, 3);
    do_op(1'b0, 2'd3, 1'b1, 32'h0000_0100, 32'h0,         3'd7, 0, 0, 0, 32'h1234_5678, 6);
`ifdef MEM_UNIT_MISALIGN_EN
    do_op(1'b0, 2'd1, 1'b1, 32'h0000_0101, 32'h0,         3'd2, 0, 0, 0, 32'h0,         1);
    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,         3'd4, 0, 0, 0, 32'h0,         1);
`else
    do_op(1'b0, 2'd1, 1'b1, 32'h0000_0101, 32'h0,         3'd2, 0, 0, 0, 32'h0000_3456, 4);
    do_op(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0,         3'd4, 0, 0, 0, 32'hFFFF_9234, 4);
`endif
    do_op(1'b1, 2'd2, 1'b0, 32'h0000_0300, 32'hA1B2_C3D4, 3'd5, 0, 0, 3, 32'h0,         0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_ram_300", {24'd0, ram[12'h300]}, 32'h0000_00D4);
    chk("abort_ram_301", {24'd0, ram[12'h301]}, 32'h0000_00C3);
    chk("abort_ram_302", {24'd0, ram[12'h302]}, 32'h0000_0000);
    do_op(1'b1, 2'd0, 1'b0, 32'h0000_0302, 32'h0000_0055, 3'd6, 1, 1, 0, 32'h0,         3);
    do_op(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0,         3'd1, 0, 0, 0, 32'h0055_C3D4, 6);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/mem_unit.md
# mem_unit

Load/store unit of the memory stage. Accepts one load or store request at a time from the issue side and performs it over the byte-wide RAM port. Byte/half/word data is assembled or split little-endian, and loads are sign- or zero-extended. Each completion is broadcast as a registered {data, tag} pair that feeds the memory result bus register directly.

## Interface
- No parameters. Widths are fixed: data 32, tag 3, RAM data 8, address 32.
- Reset is asynchronous and active-high.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `pause`  in  1  global stall; freezes the unit.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  combinational: `(state==IDLE) & !pause`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_width`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_signed`  in  1  sign-extend load (ignored for word/store).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; low bytes used.
- `req_num`  in  3  result tag; 0 means "no tag".
- `mem_din`  in  8  RAM read data; valid one cycle after the address.
- `mem_dout`  out  8  RAM write data.
- `mem_a`  out  32  RAM byte address.
- `mem_wr`  out  1  RAM write strobe.
- `data_out`  out  32  completion data (loads); 0 for stores.
- `num_out`  out  3  completion tag; 0 = empty slot.
- `misalign_out`  out  1  only with the macro; see Configuration.

## Operation
- **Transfer count.** N = 1, 2 or 4 bytes according to `req_width`.
- **Accept.** A request is taken on a posedge with `req_valid & req_ready`. All request fields are latched and `state` moves to RD or WR.
- **RD state.** In each non-paused cycle, drive `mem_a = addr+i` with `mem_wr = 0`, for i = 0..N-1.
  - The byte issued in a non-paused cycle is captured from `mem_din` on the following posedge into byte lane i. This capture happens even if `pause` is high in that following cycle; a pending flag tracks it.
  - After the last capture, go to DONE.
- **WR state.** In each non-paused cycle, drive `mem_a = addr+i`, `mem_dout = wdata[8i+7:8i]` and `mem_wr = 1`, for i = 0..N-1. After byte N-1, go to DONE.
- **DONE state.** Registered outputs take their values on entry:
  - load: `data_out` = assembled value, extended per `req_signed`/`req_width`;
  - store: `data_out` = 0;
  - `num_out` = latched tag.
- **Leaving DONE.** On the next non-paused posedge, `num_out` and `data_out` clear to 0 and `state` goes to IDLE.
- **No back-to-back accept.** No request is accepted in the cycle the result is presented.
- **Pause.** While `pause` is high:
  - `state`, byte index, latches, `mem_a`, `mem_dout`, `data_out` and `num_out` hold;
  - `mem_wr` is forced to 0.
- **Address wrap.** `addr+i` wraps modulo 2^32.
- **Idle outputs.** In IDLE: `mem_wr = 0`; `mem_a` and `mem_dout` hold their last value.
- **Reset.** Reset at any time aborts the operation. Bytes already written stay written, and no completion is broadcast.

## Timing
- **Reset values.** `state` = IDLE; `mem_a` = 0, `mem_dout` = 0, `mem_wr` = 0; `data_out` = 0, `num_out` = 0, `misalign_out` = 0. `req_ready` = 1 when `pause` = 0.
- **Cycle numbering.** The accept edge is cycle 0 (no pause).
- **Load.** Address i is driven in cycle 1+i, and byte i is captured at the end of cycle 2+i. The result is visible in cycle N+2 for exactly one cycle; `req_ready` rises in cycle N+3.
  - Latency: LB = 3, LH = 4, LW = 6.
- **Store.** Write i occurs in cycle 1+i. Completion is visible in cycle N+1; `req_ready` rises in cycle N+2.
- **Pauses.** Each paused cycle extends the latency by one. A result is never visible for zero non-paused cycles.

## Configuration
- **`MEM_UNIT_MISALIGN_EN` defined:**
  - A half access with `addr[0]` set, or a word access with `addr[1:0]` ≠ 0, issues no RAM cycle.
  - `state` goes straight to DONE: `data_out` = 0, `num_out` = tag, `misalign_out` = 1 for the same cycle(s). Completion is in cycle 1.
- **`MEM_UNIT_MISALIGN_EN` undefined:**
  - Misaligned accesses proceed bytewise as normal.
  - The `misalign_out` port is absent.

## Structure
- **Shared package:**
  - width encodings (`W_BYTE`/`W_HALF`/`W_WORD`);
  - state enum (IDLE, RD, WR, DONE);
  - `TAG_NONE` = 3'd0;
  - `TAG_W` = 3, `DATA_W` = 32.
- **Sub-module `load_extend`:** combinational; takes 32-bit assembled bytes, width and signed flag, and returns the extended 32-bit value.

## Test plan
- **LW.** RAM[0x100..0x103] = 78 56 34 12; LW tag 3 → `mem_a` = 0x100..0x103 in cycles 1–4; `data_out` = 0x12345678 with `num_out` = 3 in cycle 6 only.
- **LB / LBU.** RAM[0x40] = 0x80: LB tag 1 → 0xFFFFFF80; LBU tag 2 → 0x00000080; each in cycle 3.
- **SH.** SH 0x1234BEEF at 0x200, tag 5 → `mem_wr` in cycles 1–2 writing EF@0x200 and BE@0x201; `num_out` = 5 and `data_out` = 0 in cycle 3.
- **Pause.** Pause held high for 3 cycles starting in cycle 2 of the LW → correct 0x12345678 in cycle 9; `mem_wr` stays 0; `num_out` held while paused.
- **Reset mid-store.** `rst` pulse during byte 2 of an SW → all outputs 0 immediately; no `num_out` pulse; the next request is accepted normally.
- **Misalign (macro on).** LW at 0x102, tag 4 → no `mem_a` change; cycle 1 shows `num_out` = 4, `data_out` = 0, `misalign_out` = 1.
